// File: rtl/alu_writeback.sv
// Writeback stage behind the combinational ALU: drives the register-file write port
// (one beat, or low/high beats for MUL), holds the Z/C flag register and counts retired ops.
module alu_writeback #(
  parameter int          DATA_W     = 32,
  parameter int          REG_ADDR_W = 5,
  parameter logic [3:0]  MUL_OP     = 4'b0010
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [3:0]              alu_opcode,
  input  logic [2*DATA_W-1:0]     data_in,
  input  logic                    z_flag_in,
  input  logic                    carry_flag_in,
  input  logic                    flag_we,
  input  logic [REG_ADDR_W-1:0]   rd_addr,
  input  logic [REG_ADDR_W-1:0]   rd_hi_addr,
  output logic                    rf_we,
  output logic [REG_ADDR_W-1:0]   rf_waddr,
  output logic [DATA_W-1:0]       rf_wdata,
  output logic                    z_flag_q,
  output logic                    carry_flag_q,
  output logic [31:0]             retire_count,
  output logic                    busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WR_LO = 2'd1;
  localparam logic [1:0] WR_HI = 2'd2;

  logic [1:0]            state_reg, state_next;
  logic                  is_mul_reg;
  logic [DATA_W-1:0]     data_hi_reg;
  logic [REG_ADDR_W-1:0] rd_hi_reg;
  logic                  rf_we_reg;
  logic [REG_ADDR_W-1:0] rf_waddr_reg;
  logic [DATA_W-1:0]     rf_wdata_reg;
  logic                  z_flag_reg, carry_flag_reg;
  logic [31:0]           retire_count_reg;
  logic [DATA_W-1:0]     in_word [2];
  logic                  accept;
  logic                  last_beat;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_word
      assign in_word[gi] = data_in[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // The low beat is registered straight from the inputs on accept, so only the
  // high half and its address need to be held for a MUL.
  assign in_ready  = !rst && ((state_reg == IDLE) ||
                              (state_reg == WR_LO && !is_mul_reg) ||
                              (state_reg == WR_HI));
  assign accept    = in_valid && in_ready;
  assign last_beat = (state_reg == WR_LO && !is_mul_reg) || (state_reg == WR_HI);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = WR_LO;
      WR_LO:   if (is_mul_reg) state_next = WR_HI;
               else state_next = accept ? WR_LO : IDLE;
      WR_HI:   state_next = accept ? WR_LO : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      is_mul_reg       <= 1'b0;
      data_hi_reg      <= '0;
      rd_hi_reg        <= '0;
      rf_we_reg        <= 1'b0;
      rf_waddr_reg     <= '0;
      rf_wdata_reg     <= '0;
      z_flag_reg       <= 1'b0;
      carry_flag_reg   <= 1'b0;
      retire_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (last_beat)
        retire_count_reg <= retire_count_reg + 32'd1;
      if (accept) begin
        is_mul_reg   <= (alu_opcode == MUL_OP);
        data_hi_reg  <= in_word[1];
        rd_hi_reg    <= rd_hi_addr;
        rf_we_reg    <= (rd_addr != '0);
        rf_waddr_reg <= rd_addr;
        rf_wdata_reg <= in_word[0];
        if (flag_we) begin
          z_flag_reg     <= z_flag_in;
          carry_flag_reg <= carry_flag_in;
        end
      end else if (state_reg == WR_LO && is_mul_reg) begin
        rf_we_reg    <= (rd_hi_reg != '0);
        rf_waddr_reg <= rd_hi_reg;
        rf_wdata_reg <= data_hi_reg;
      end else begin
        rf_we_reg <= 1'b0;
      end
    end
  end

  assign rf_we        = rf_we_reg;
  assign rf_waddr     = rf_waddr_reg;
  assign rf_wdata     = rf_wdata_reg;
  assign z_flag_q     = z_flag_reg;
  assign carry_flag_q = carry_flag_reg;
  assign retire_count = retire_count_reg;
  assign busy         = (state_reg != IDLE);

endmodule
